uartrx_cfg: RTL and testbench

Parametrised UART receiver, the next generation of the 8N1 `uartrx`. It runs entirely on the system clock, using a clock-enable tick rather than a derived clock. It oversamples the line and samples each bit mid-bit. Frame format is configurable (5–9 data bits, optional parity, 1 or 2 stop bits). Received words go out through a valid/ready handshake, with per-word parity and framing flags and an overrun pulse. It sits between the `rx` pad and any byte-stream consumer (FIFO, command decoder).

---
 rtl/uartrx_cfg.sv | 210 +++++++++++++++++++++
 tb/tb_uartrx_cfg.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/uartrx_cfg.sv
// Oversampling UART receiver on clk with a clock-enable tick. Frame format is
// set by parameters; received words are delivered over a valid/ready handshake.
//
// state   | meaning
// IDLE    | waiting for a synchronised falling edge on rx
// START   | counting to mid start bit to confirm it (a high sample is a false start)
// DATA    | sampling DATA_BITS data bits mid-bit, LSB first
// PARITY  | sampling the parity bit and latching any mismatch
// STOP    | sampling STOP_BITS stop bits, then completing the frame
module uartrx_cfg #(
  parameter int CLK_FREQ   = 1000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int DIV  = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIVW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SCW  = $clog2(OVERSAMPLE);

  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(DIV - 1);
  localparam logic [SCW-1:0]  SC_MID   = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0]  SC_LAST  = SCW'(OVERSAMPLE - 1);
  localparam logic [3:0]      BIT_LAST = 4'(DATA_BITS - 1);
  localparam logic            STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic            ODD       = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e                 state_q, state_d;
  logic [DIVW-1:0]        div_q, div_d;
  logic                   sync1_q, sync2_q, prev_q;
  logic [SCW-1:0]         sc_q, sc_d;
  logic [3:0]             bit_q, bit_d;
  logic                   stop_q, stop_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   pe_q, pe_d;
  logic                   fe_q, fe_d;
  logic                   ovr_q, ovr_d;
  logic                   tick;
  logic                   done;
  logic                   accept;

  assign tick  = (div_q == DIV_LAST);
  assign div_d = tick ? '0 : div_q + 1'b1;

  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    done    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = S_START;
          sc_d    = '0;
          bit_d   = '0;
          stop_d  = 1'b0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      S_START: begin
        if (tick) begin
          if (sc_q == SC_MID) begin
            sc_d    = '0;
            state_d = sync2_q ? S_IDLE : S_DATA;
          end else begin
            sc_d = sc_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          sc_d = sc_q + 1'b1;
          if (sc_q == SC_LAST) begin
            shift_d = {sync2_q, shift_q[DATA_BITS-1:1]};
            if (bit_q == BIT_LAST) begin
              bit_d   = '0;
              state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          sc_d = sc_q + 1'b1;
          if (sc_q == SC_LAST) begin
            perr_d  = sync2_q ^ (^shift_q) ^ ODD;
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          sc_d = sc_q + 1'b1;
          if (sc_q == SC_LAST) begin
            ferr_d = ferr_q | ~sync2_q;
            if (stop_q == STOP_LAST) begin
              done    = 1'b1;
              state_d = S_IDLE;
            end else begin
              stop_d = 1'b1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A word accepted in the same cycle a frame completes frees the slot for it.
  always_comb begin
    accept  = valid_q && rx_ready;
    data_d  = data_q;
    valid_d = valid_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    ovr_d   = 1'b0;
    if (done) begin
      if (!valid_q || accept) begin
        data_d  = shift_q;
        valid_d = 1'b1;
        pe_d    = perr_q;
        fe_d    = ferr_d;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      sc_q    <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      sync1_q <= rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      sc_q    <= sc_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign parity_err  = pe_q;
  assign frame_err   = fe_q;
  assign overrun_err = ovr_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uartrx_cfg.sv
// Bench for uartrx_cfg: an 8N1 receiver (A) and an 8E2 receiver (B) driven by
// directed and random frames, checked against frame-level expectations.
module tb_uartrx_cfg;

  localparam int BIT_CLK = 160;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       rx_a, rdy_a, val_a, pe_a, fe_a, ovr_a, busy_a;
  logic [7:0] dat_a;
  logic       rx_b, rdy_b, val_b, pe_b, fe_b, ovr_b, busy_b;
  logic [7:0] dat_b;

  uartrx_cfg #(.CLK_FREQ(1600000), .BAUD_RATE(10000), .OVERSAMPLE(16)) dut_a (
    .clk(clk), .rst(rst), .rx(rx_a), .rx_ready(rdy_a), .rx_data(dat_a),
    .rx_valid(val_a), .parity_err(pe_a), .frame_err(fe_a),
    .overrun_err(ovr_a), .busy(busy_a)
  );

  uartrx_cfg #(.CLK_FREQ(1600000), .BAUD_RATE(10000), .OVERSAMPLE(16),
               .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .rx(rx_b), .rx_ready(rdy_b), .rx_data(dat_b),
    .rx_valid(val_b), .parity_err(pe_b), .frame_err(fe_b),
    .overrun_err(ovr_b), .busy(busy_b)
  );

  int compared = 0;
  int mismatched = 0;

  // Activity seen at negedges, well away from the active edge.
  int hs_a = 0, vcyc_a = 0, ovrc_a = 0, busyc_a = 0, hs_b = 0;
  logic [7:0] cap_d_a = '0, cap_d_b = '0;
  logic cap_pe_a = 1'b0, cap_fe_a = 1'b0, cap_pe_b = 1'b0, cap_fe_b = 1'b0;

  always @(negedge clk) begin
    if (val_a) vcyc_a <= vcyc_a + 1;
    if (ovr_a) ovrc_a <= ovrc_a + 1;
    if (busy_a) busyc_a <= busyc_a + 1;
    if (val_a && rdy_a) begin
      hs_a <= hs_a + 1; cap_d_a <= dat_a; cap_pe_a <= pe_a; cap_fe_a <= fe_a;
    end
    if (val_b && rdy_b) begin
      hs_b <= hs_b + 1; cap_d_b <= dat_b; cap_pe_b <= pe_b; cap_fe_b <= fe_b;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit to_b, input logic v);
    if (to_b) rx_b = v; else rx_a = v;
  endtask

  // Line-level frame: start, data LSB first, optional parity, stop bits, idle gap.
  task automatic send(input bit to_b, input logic [7:0] d, input bit par_en,
                      input logic par_bit, input logic [1:0] stops, input int nstop);
    drive(to_b, 1'b0); cyc(BIT_CLK);
    for (int i = 0; i < 8; i++) begin drive(to_b, d[i]); cyc(BIT_CLK); end
    if (par_en) begin drive(to_b, par_bit); cyc(BIT_CLK); end
    for (int i = 0; i < nstop; i++) begin drive(to_b, stops[i]); cyc(BIT_CLK); end
    drive(to_b, 1'b1); cyc(20);
  endtask

  // Reference rules: even parity over the data, frame error if any stop bit is 0.
  function automatic logic exp_pe(input logic [7:0] d, input logic par_bit);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return par_bit != logic'(ones % 2);
  endfunction

  function automatic logic exp_fe(input logic [1:0] stops, input int nstop);
    for (int i = 0; i < nstop; i++) if (stops[i] == 1'b0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic frame_a(input string tag, input logic [7:0] d, input logic stop);
    int h0 = hs_a;
    send(1'b0, d, 1'b0, 1'b0, {1'b1, stop}, 1);
    chk({tag, "_hs"}, 32'(hs_a - h0), 32'd1);
    chk({tag, "_data"}, 32'(cap_d_a), 32'(d));
    chk({tag, "_flags"}, {30'd0, cap_pe_a, cap_fe_a}, {30'd0, 1'b0, exp_fe({1'b1, stop}, 1)});
  endtask

  task automatic frame_b(input string tag, input logic [7:0] d, input logic par_bit,
                         input logic [1:0] stops);
    int h0 = hs_b;
    send(1'b1, d, 1'b1, par_bit, stops, 2);
    chk({tag, "_hs"}, 32'(hs_b - h0), 32'd1);
    chk({tag, "_data"}, 32'(cap_d_b), 32'(d));
    chk({tag, "_flags"}, {30'd0, cap_pe_b, cap_fe_b},
        {30'd0, exp_pe(d, par_bit), exp_fe(stops, 2)});
  endtask

  initial begin
    int v0, b0, o0;
    logic [7:0] d;
    logic [7:0] r;

    rst = 1'b0; rx_a = 1'b1; rx_b = 1'b1; rdy_a = 1'b1; rdy_b = 1'b1;
    cyc(5);
    chk("reset_a", {19'd0, dat_a, val_a, pe_a, fe_a, ovr_a, busy_a}, 32'd0);
    chk("reset_b", {19'd0, dat_b, val_b, pe_b, fe_b, ovr_b, busy_b}, 32'd0);
    rst = 1'b1;
    cyc(20);

    v0 = vcyc_a;
    frame_a("t1_a5", 8'hA5, 1'b1);
    chk("t1_valid_cycles", 32'(vcyc_a - v0), 32'd1);

    frame_b("t2_par_bad", 8'h03, 1'b1, 2'b11);
    frame_b("t2_par_ok", 8'h03, 1'b0, 2'b11);
    frame_b("t2_stop2_bad", 8'h81, 1'b0, 2'b01);

    frame_a("t3_stop_bad", 8'h55, 1'b0);
    frame_a("t3_stop_ok", 8'h0F, 1'b1);

    v0 = vcyc_a; b0 = busyc_a;
    rx_a = 1'b0; cyc(40); rx_a = 1'b1;
    for (int i = 0; i < 100 && busy_a; i++) cyc(1);
    chk("t4_busy_clear", 32'(busy_a), 32'd0);
    chk("t4_busy_seen", 32'(busyc_a > b0), 32'd1);
    cyc(200);
    chk("t4_no_valid", 32'(vcyc_a - v0), 32'd0);

    rdy_a = 1'b0; o0 = ovrc_a;
    send(1'b0, 8'h11, 1'b0, 1'b0, 2'b11, 1);
    send(1'b0, 8'h22, 1'b0, 1'b0, 2'b11, 1);
    chk("t5_held_valid", 32'(val_a), 32'd1);
    chk("t5_held_data", 32'(dat_a), 32'h11);
    chk("t5_overrun", 32'(ovrc_a - o0), 32'd1);
    rdy_a = 1'b1;
    cyc(1);
    chk("t5_valid_drop", 32'(val_a), 32'd0);
    chk("t5_accepted", 32'(cap_d_a), 32'h11);

    d = 8'h3C;
    rx_a = 1'b0; cyc(BIT_CLK);
    for (int i = 0; i < 4; i++) begin rx_a = d[i]; cyc(BIT_CLK); end
    rx_a = d[4]; cyc(80);
    rst = 1'b0;
    cyc(1);
    chk("t6_in_reset", {19'd0, dat_a, val_a, pe_a, fe_a, ovr_a, busy_a}, 32'd0);
    rx_a = 1'b1;
    cyc(10);
    chk("t6_in_reset_late", {19'd0, dat_a, val_a, pe_a, fe_a, ovr_a, busy_a}, 32'd0);
    rst = 1'b1;
    cyc(20);
    frame_a("t6_3c", 8'h3C, 1'b1);

    for (int k = 0; k < 6; k++) begin
      d = 8'($urandom);
      frame_a("rnd_a", d, ($urandom_range(0, 3) != 0));
    end
    for (int k = 0; k < 6; k++) begin
      d = 8'($urandom);
      r = 8'($urandom);
      frame_b("rnd_b", d, r[0], {(r[3:1] != 0), (r[6:4] != 0)});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
